// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, shift-type codes,
// status-register bit positions and a rotate helper.
package exe_pkg;

    // ALU opcodes carried in EXE_CMD
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    // Immediate-shift types in Shift_operand[6:5]
    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    // Bit positions of the flags inside SR = {N,Z,C,V}
    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    // 32-bit rotate right; an amount of 0 returns x unchanged
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] dbl;
        dbl = {x, x} >> n;
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU with NZCV generation. cv_update marks the arithmetic
// ops whose C/V are meaningful; op_valid is low for unassigned opcodes,
// which produce 0 and must leave every flag untouched.
module exe_alu
    import exe_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    input  logic [3:0]  cmd,
    output logic [31:0] res,
    output logic [3:0]  nzcv,
    output logic        cv_update,
    output logic        op_valid
);

    logic [32:0] sum;
    logic        c_flag;
    logic        v_flag;

    // Compute result and raw flags for the selected opcode
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can
        // leave a variable unassigned and infer a latch.
        sum       = 33'd0;
        res       = 32'd0;
        c_flag    = 1'b0;
        v_flag    = 1'b0;
        cv_update = 1'b0;
        op_valid  = 1'b1;
        case (cmd)
            EXE_MOV: res = b;
            EXE_MVN: res = ~b;
            EXE_AND: res = a & b;
            EXE_ORR: res = a | b;
            EXE_EOR: res = a ^ b;
            EXE_ADD, EXE_ADC: begin
                sum       = {1'b0, a} + {1'b0, b} + {32'd0, cin & (cmd == EXE_ADC)};
                res       = sum[31:0];
                c_flag    = sum[32];
                v_flag    = (a[31] == b[31]) && (res[31] != a[31]);
                cv_update = 1'b1;
            end
            EXE_SUB, EXE_SBC: begin
                // Subtract as a + ~b + carry-in; SUB forces the carry-in to 1
                sum       = {1'b0, a} + {1'b0, ~b} + {32'd0, (cmd == EXE_SUB) | cin};
                res       = sum[31:0];
                c_flag    = sum[32];
                v_flag    = (a[31] != b[31]) && (res[31] != a[31]);
                cv_update = 1'b1;
            end
            default: op_valid = 1'b0;
        endcase
        nzcv = {res[31], (res == 32'd0), c_flag, v_flag};
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 generator, ALU, NZCV status register, branch-target
// adder and the EX/MEM pipeline register.
// Optional feature: define EXE_FORWARDING_EN to add operand-forwarding
// muxes (Sel_Src1/Sel_Src2, MEM_ALU_Res_In, WB_Value_In).
module exe_stage
    import exe_pkg::*;
#(
    parameter logic [3:0] SR_RESET = 4'b0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        freeze,
    input  logic        WB_EN_In,
    input  logic        MEM_R_EN_In,
    input  logic        MEM_W_EN_In,
    input  logic        B_In,
    input  logic        S_In,
    input  logic [3:0]  EXE_CMD_In,
    input  logic [31:0] PC_In,
    input  logic [31:0] Val_Rn_In,
    input  logic [31:0] Val_Rm_In,
    input  logic        imm_In,
    input  logic [11:0] Shift_operand_In,
    input  logic [23:0] Signed_imm_24_In,
    input  logic [3:0]  Dest_In,
    output logic        Branch_Taken,
    output logic [31:0] Branch_Address,
    output logic [3:0]  SR,
    output logic        WB_EN_Out,
    output logic        MEM_R_EN_Out,
    output logic        MEM_W_EN_Out,
    output logic [31:0] ALU_Res_Out,
    output logic [31:0] Val_Rm_Out,
    output logic [3:0]  Dest_Out
`ifdef EXE_FORWARDING_EN
    ,
    input  logic [1:0]  Sel_Src1,
    input  logic [1:0]  Sel_Src2,
    input  logic [31:0] MEM_ALU_Res_In,
    input  logic [31:0] WB_Value_In
`endif
);

    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] val2;
    logic [31:0] alu_res;
    logic [3:0]  alu_nzcv;
    logic        alu_cv_update;
    logic        alu_op_valid;
    logic [3:0]  new_flags;
    logic [4:0]  shift_amt;

`ifdef EXE_FORWARDING_EN
    // Select operands from ID/EX, MEM or WB; code 11 falls back to ID/EX
    always_comb begin
        src1 = Val_Rn_In;
        src2 = Val_Rm_In;
        case (Sel_Src1)
            2'b01:   src1 = MEM_ALU_Res_In;
            2'b10:   src1 = WB_Value_In;
            default: src1 = Val_Rn_In;
        endcase
        case (Sel_Src2)
            2'b01:   src2 = MEM_ALU_Res_In;
            2'b10:   src2 = WB_Value_In;
            default: src2 = Val_Rm_In;
        endcase
    end
`else
    assign src1 = Val_Rn_In;
    assign src2 = Val_Rm_In;
`endif

    assign shift_amt = Shift_operand_In[11:7];

    // Val2: memory offset, rotated immediate, or immediate-shifted Rm
    always_comb begin
        val2 = src2;
        if (MEM_R_EN_In || MEM_W_EN_In) begin
            val2 = {20'd0, Shift_operand_In};
        end else if (imm_In) begin
            val2 = ror32({24'd0, Shift_operand_In[7:0]}, {Shift_operand_In[11:8], 1'b0});
        end else if (!Shift_operand_In[4]) begin
            case (Shift_operand_In[6:5])
                SHIFT_LSL: val2 = src2 << shift_amt;
                SHIFT_LSR: val2 = src2 >> shift_amt;
                SHIFT_ASR: val2 = $signed(src2) >>> shift_amt;
                default:   val2 = ror32(src2, shift_amt);
            endcase
        end
    end

    exe_alu u_alu (
        .a         (src1),
        .b         (val2),
        .cin       (SR[SR_C]),
        .cmd       (EXE_CMD_In),
        .res       (alu_res),
        .nzcv      (alu_nzcv),
        .cv_update (alu_cv_update),
        .op_valid  (alu_op_valid)
    );

    // Merge ALU flags with the current SR: logical ops keep C/V, unknown ops keep all
    always_comb begin
        new_flags = SR;
        if (alu_op_valid) begin
            new_flags[SR_N] = alu_nzcv[SR_N];
            new_flags[SR_Z] = alu_nzcv[SR_Z];
            if (alu_cv_update) begin
                new_flags[SR_C] = alu_nzcv[SR_C];
                new_flags[SR_V] = alu_nzcv[SR_V];
            end
        end
    end

    assign Branch_Taken   = B_In;
    assign Branch_Address = PC_In + {{6{Signed_imm_24_In[23]}}, Signed_imm_24_In, 2'b00};

    // Status register: written only by S-instructions that are not stalled
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            SR <= SR_RESET;
        end else if (S_In && !freeze) begin
            // NOTE: clocked state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            SR <= new_flags;
        end
    end

    // EX/MEM pipeline register, held while the memory stage stalls
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            WB_EN_Out    <= 1'b0;
            MEM_R_EN_Out <= 1'b0;
            MEM_W_EN_Out <= 1'b0;
            ALU_Res_Out  <= 32'd0;
            Val_Rm_Out   <= 32'd0;
            Dest_Out     <= 4'd0;
        end else if (!freeze) begin
            WB_EN_Out    <= WB_EN_In;
            MEM_R_EN_Out <= MEM_R_EN_In;
            MEM_W_EN_Out <= MEM_W_EN_In;
            ALU_Res_Out  <= alu_res;
            Val_Rm_Out   <= src2;
            Dest_Out     <= Dest_In;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vectors, a behavioural model
// of the stage, a per-cycle compare process and literal spot checks.
module tb_exe_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        freeze = 1'b0;
    logic        WB_EN_In = 1'b0, MEM_R_EN_In = 1'b0, MEM_W_EN_In = 1'b0, B_In = 1'b0, S_In = 1'b0;
    logic [3:0]  EXE_CMD_In = 4'd0;
    logic [31:0] PC_In = 32'd0, Val_Rn_In = 32'd0, Val_Rm_In = 32'd0;
    logic        imm_In = 1'b0;
    logic [11:0] Shift_operand_In = 12'd0;
    logic [23:0] Signed_imm_24_In = 24'd0;
    logic [3:0]  Dest_In = 4'd0;
    logic        Branch_Taken;
    logic [31:0] Branch_Address;
    logic [3:0]  SR;
    logic        WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out;
    logic [31:0] ALU_Res_Out, Val_Rm_Out;
    logic [3:0]  Dest_Out;
`ifdef EXE_FORWARDING_EN
    logic [1:0]  Sel_Src1 = 2'd0, Sel_Src2 = 2'd0;
    logic [31:0] MEM_ALU_Res_In = 32'd0, WB_Value_In = 32'd0;
`endif

    exe_stage dut (
        .CLK (CLK), .RST (RST), .freeze (freeze),
        .WB_EN_In (WB_EN_In), .MEM_R_EN_In (MEM_R_EN_In), .MEM_W_EN_In (MEM_W_EN_In),
        .B_In (B_In), .S_In (S_In), .EXE_CMD_In (EXE_CMD_In), .PC_In (PC_In),
        .Val_Rn_In (Val_Rn_In), .Val_Rm_In (Val_Rm_In), .imm_In (imm_In),
        .Shift_operand_In (Shift_operand_In), .Signed_imm_24_In (Signed_imm_24_In),
        .Dest_In (Dest_In), .Branch_Taken (Branch_Taken), .Branch_Address (Branch_Address),
        .SR (SR), .WB_EN_Out (WB_EN_Out), .MEM_R_EN_Out (MEM_R_EN_Out),
        .MEM_W_EN_Out (MEM_W_EN_Out), .ALU_Res_Out (ALU_Res_Out),
        .Val_Rm_Out (Val_Rm_Out), .Dest_Out (Dest_Out)
`ifdef EXE_FORWARDING_EN
        ,
        .Sel_Src1 (Sel_Src1), .Sel_Src2 (Sel_Src2),
        .MEM_ALU_Res_In (MEM_ALU_Res_In), .WB_Value_In (WB_Value_In)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        wb, mr, mw, b, s, imm, frz;
        logic [3:0]  cmd;
        logic [31:0] pc, rn, rm;
        logic [11:0] so;
        logic [23:0] simm;
        logic [3:0]  dest;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model state: what the registered and combinational outputs must be
    logic [3:0]  m_sr;
    logic        m_wb, m_mr, m_mw, m_bt;
    logic [31:0] m_res, m_rm, m_baddr;
    logic [3:0]  m_dest;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_sr = 4'b0000; m_wb = 0; m_mr = 0; m_mw = 0;
        m_res = 0; m_rm = 0; m_dest = 0;
    endtask

    // Operand-2 per the shifter rules, done one bit-step at a time
    function automatic logic [31:0] m_val2(input logic mem, input logic imm,
                                           input logic [11:0] so, input logic [31:0] rm);
        logic [31:0] v;
        if (mem) return {20'd0, so};
        if (imm) begin
            v = {24'd0, so[7:0]};
            for (int i = 0; i < 2 * so[11:8]; i++) v = {v[0], v[31:1]};
            return v;
        end
        if (so[4]) return rm;
        v = rm;
        for (int i = 0; i < so[11:7]; i++) begin
            case (so[6:5])
                2'b00:   v = {v[30:0], 1'b0};
                2'b01:   v = {1'b0, v[31:1]};
                2'b10:   v = {v[31], v[31:1]};
                default: v = {v[0], v[31:1]};
            endcase
        end
        return v;
    endfunction

    // ALU from wide integer arithmetic; returns result and next flags
    task automatic m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sr, output logic [31:0] res, output logic [3:0] nf);
        longint sa, sb, s;
        logic [63:0] u;
        logic c, v, ci;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ci = sr[1]; c = sr[1]; v = sr[0]; s = 0;
        case (cmd)
            4'b0001: res = b;
            4'b1001: res = ~b;
            4'b0110: res = a & b;
            4'b0111: res = a | b;
            4'b1000: res = a ^ b;
            4'b0010, 4'b0011: begin
                u = {32'd0, a} + {32'd0, b} + ((cmd == 4'b0011) ? 64'(ci) : 64'd0);
                res = u[31:0]; c = u[32];
                s = sa + sb + ((cmd == 4'b0011) ? longint'(ci) : 0);
                v = (longint'(int'(s)) != s);
            end
            4'b0100: begin
                res = a - b; c = (a >= b);
                s = sa - sb; v = (longint'(int'(s)) != s);
            end
            4'b0101: begin
                res = a - b - {31'd0, ~ci};
                c = ({32'd0, a} >= {32'd0, b} + 64'(~ci));
                s = sa - sb - longint'(~ci); v = (longint'(int'(s)) != s);
            end
            default: begin
                res = 32'd0; nf = sr;
                return;
            end
        endcase
        nf = {res[31], res == 32'd0, c, v};
    endtask

    // Apply one ID/EX vector, predict, clock it and settle model registers
    task automatic step(input vec_t v);
        logic [31:0] rn_e, rm_e, val2, res;
        logic [3:0]  nf;
        int off;
        WB_EN_In = v.wb; MEM_R_EN_In = v.mr; MEM_W_EN_In = v.mw; B_In = v.b; S_In = v.s;
        EXE_CMD_In = v.cmd; PC_In = v.pc; Val_Rn_In = v.rn; Val_Rm_In = v.rm;
        imm_In = v.imm; Shift_operand_In = v.so; Signed_imm_24_In = v.simm;
        Dest_In = v.dest; freeze = v.frz;
        rn_e = v.rn; rm_e = v.rm;
`ifdef EXE_FORWARDING_EN
        if (Sel_Src1 == 2'd1) rn_e = MEM_ALU_Res_In; else if (Sel_Src1 == 2'd2) rn_e = WB_Value_In;
        if (Sel_Src2 == 2'd1) rm_e = MEM_ALU_Res_In; else if (Sel_Src2 == 2'd2) rm_e = WB_Value_In;
`endif
        off = $signed(v.simm);
        m_baddr = v.pc + 32'(off * 4);
        m_bt = v.b;
        val2 = m_val2(v.mr | v.mw, v.imm, v.so, rm_e);
        m_alu(v.cmd, rn_e, val2, m_sr, res, nf);
        @(posedge CLK); #1;
        if (!v.frz) begin
            m_wb = v.wb; m_mr = v.mr; m_mw = v.mw;
            m_res = res; m_rm = rm_e; m_dest = v.dest;
            if (v.s) m_sr = nf;
        end
        @(negedge CLK); #1;
    endtask

    function automatic vec_t mk(input logic [3:0] cmd, input logic [31:0] rn,
                                input logic [31:0] rm, input logic [11:0] so, input logic s);
        vec_t v;
        v = '0;
        v.cmd = cmd; v.rn = rn; v.rm = rm; v.so = so; v.s = s;
        return v;
    endfunction

    // Compare every observable output against the model mid-cycle
    always @(negedge CLK) begin
        if (chk_en) begin
            check("sr",       {28'd0, SR},           {28'd0, m_sr});
            check("wb_en",    {31'd0, WB_EN_Out},    {31'd0, m_wb});
            check("mem_r_en", {31'd0, MEM_R_EN_Out}, {31'd0, m_mr});
            check("mem_w_en", {31'd0, MEM_W_EN_Out}, {31'd0, m_mw});
            check("alu_res",  ALU_Res_Out,           m_res);
            check("val_rm",   Val_Rm_Out,            m_rm);
            check("dest",     {28'd0, Dest_Out},     {28'd0, m_dest});
            check("br_taken", {31'd0, Branch_Taken}, {31'd0, m_bt});
            check("br_addr",  Branch_Address,        m_baddr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        m_reset(); m_bt = 0; m_baddr = 0;
        #1;
        check("rst_sr",  {28'd0, SR}, 32'h0);
        check("rst_res", ALU_Res_Out, 32'h0);
        check("rst_wb",  {31'd0, WB_EN_Out}, 32'h0);
        repeat (2) @(negedge CLK);
        #1 RST = 1'b1;
        chk_en = 1'b1;

        v = mk(4'b0010, 32'd5, 32'd7, 12'h000, 0); v.wb = 1; v.dest = 4'd3; step(v);
        check("add_5_7", ALU_Res_Out, 32'd12);
        step(mk(4'b0100, 32'd3, 32'd3, 12'h000, 1));
        check("sub_zero_res", ALU_Res_Out, 32'd0);
        check("sub_zero_sr", {28'd0, SR}, 32'b0110);
        step(mk(4'b0010, 32'h7FFF_FFFF, 32'd1, 12'h000, 1));
        check("add_ovf_res", ALU_Res_Out, 32'h8000_0000);
        check("add_ovf_sr", {28'd0, SR}, 32'b1001);
        v = mk(4'b0001, 32'd0, 32'd0, 12'h4FF, 0); v.imm = 1; step(v);
        check("mov_imm", ALU_Res_Out, 32'hFF00_0000);
        step(mk(4'b0001, 32'd0, 32'h8000_0000, 12'h240, 0));
        check("asr4", ALU_Res_Out, 32'hF800_0000);
        step(mk(4'b0001, 32'd0, 32'h0000_0001, 12'h0E0, 0));
        check("ror1", ALU_Res_Out, 32'h8000_0000);
        step(mk(4'b0001, 32'd0, 32'd3, 12'hF80, 0));
        step(mk(4'b0001, 32'd0, 32'h1234, 12'h020, 0));
        check("lsr0_identity", ALU_Res_Out, 32'h1234);
        step(mk(4'b0001, 32'd0, 32'h1234, 12'h0B0, 0));
        v = mk(4'b0010, 32'h1000, 32'd0, 12'hABC, 0); v.mr = 1; v.wb = 1; v.imm = 1; v.dest = 4'd9; step(v);
        check("ldr_addr", ALU_Res_Out, 32'h1ABC);
        v = mk(4'b0010, 32'h2000, 32'hDEAD_BEEF, 12'h004, 0); v.mw = 1; step(v);
        check("str_data", Val_Rm_Out, 32'hDEAD_BEEF);
        step(mk(4'b0100, 32'd5, 32'd3, 12'h000, 1));
        step(mk(4'b0011, 32'd1, 32'd1, 12'h000, 0));
        check("adc_c1", ALU_Res_Out, 32'd3);
        step(mk(4'b0101, 32'd5, 32'd3, 12'h000, 1));
        step(mk(4'b0100, 32'd0, 32'd1, 12'h000, 1));
        step(mk(4'b0101, 32'd5, 32'd3, 12'h000, 1));
        check("sbc_c0", ALU_Res_Out, 32'd1);
        step(mk(4'b0110, 32'hF0F0, 32'hFF00, 12'h000, 1));
        step(mk(4'b0111, 32'hF0F0, 32'hFF00, 12'h000, 1));
        step(mk(4'b1000, 32'hF0F0, 32'hFF00, 12'h000, 1));
        step(mk(4'b1001, 32'd0, 32'd0, 12'h000, 1));
        check("mvn_sr", {28'd0, SR}, 32'b1010);
        step(mk(4'b1111, 32'd9, 32'd9, 12'h000, 1));
        check("bad_cmd_res", ALU_Res_Out, 32'd0);
        check("bad_cmd_sr", {28'd0, SR}, 32'b1010);
        v = mk(4'b0010, 32'd0, 32'd0, 12'h000, 0); v.b = 1; v.pc = 32'h100; v.simm = 24'hFFFFFE; step(v);
        check("br_back", Branch_Address, 32'h0000_00F8);
        check("br_taken_lit", {31'd0, Branch_Taken}, 32'd1);
        v.pc = 32'hFFFF_FFFC; v.simm = 24'h000001; step(v);
        check("br_wrap", Branch_Address, 32'h0);
        step(mk(4'b0010, 32'h8000_0000, 32'h8000_0000, 12'h000, 1));
        check("add_neg_ovf_sr", {28'd0, SR}, 32'b0111);

        v = mk(4'b0100, 32'd10, 32'd4, 12'h000, 1); v.wb = 1; v.dest = 4'd5; v.frz = 1;
        repeat (3) step(v);
        check("frz_res", ALU_Res_Out, 32'd0);
        check("frz_sr", {28'd0, SR}, 32'b0111);
        v.frz = 0; step(v);
        check("unfrz_res", ALU_Res_Out, 32'd6);
        check("unfrz_sr", {28'd0, SR}, 32'b0010);

        v = mk(4'b0010, 32'h8000_0000, 32'h8000_0000, 12'h000, 1); v.wb = 1; v.frz = 1; step(v);
        RST = 1'b0; #1;
        m_reset();
        check("rst_mid_sr", {28'd0, SR}, 32'h0);
        check("rst_mid_res", ALU_Res_Out, 32'h0);
        check("rst_mid_dest", {28'd0, Dest_Out}, 32'h0);
        repeat (2) @(negedge CLK);
        #1 RST = 1'b1;
        v = mk(4'b0010, 32'd5, 32'd7, 12'h000, 0); v.wb = 1; step(v);
        check("post_rst_add", ALU_Res_Out, 32'd12);

`ifdef EXE_FORWARDING_EN
        Sel_Src1 = 2'b01; MEM_ALU_Res_In = 32'd10;
        step(mk(4'b0010, 32'd99, 32'd1, 12'h000, 0));
        check("fwd_mem_add", ALU_Res_Out, 32'd11);
        Sel_Src1 = 2'b00; Sel_Src2 = 2'b10; WB_Value_In = 32'h55;
        step(mk(4'b0001, 32'd0, 32'd7, 12'h000, 0));
        check("fwd_wb_rm", Val_Rm_Out, 32'h55);
        Sel_Src2 = 2'b00;
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM-subset pipeline, placed directly downstream of the ID/EX pipeline register. Holds the combinational Val2 generator and ALU, the 4-bit status register (NZCV) that feeds condition checking in ID, and the branch-target adder back to IF. It ends in the EX/MEM pipeline register, so memory-stage signals appear one cycle after the ID/EX outputs.

## Interface
- SR_RESET, 4'b0000, status register value after reset
- CLK  in  1  clock, rising-edge
- RST  in  1  asynchronous, active-low reset
- freeze  in  1  hold EX/MEM register and SR (memory stall)
- WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In  in  1 each  control from ID/EX register
- EXE_CMD_In  in  4  ALU opcode
- PC_In  in  32  PC+4 of the instruction
- Val_Rn_In, Val_Rm_In  in  32 each  register operands
- imm_In  in  1  immediate-operand flag
- Shift_operand_In  in  12  shifter operand field
- Signed_imm_24_In  in  24  branch offset
- Dest_In  in  4  destination register
- Branch_Taken  out  1  combinational, equals B_In
- Branch_Address  out  32  combinational branch target
- SR  out  4  status register {N,Z,C,V}, bit 3 = N
- WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out  out  1 each  registered control
- ALU_Res_Out  out  32  registered ALU result
- Val_Rm_Out  out  32  registered store data
- Dest_Out  out  4  registered destination

## Operation
- Val2:
  - MEM_R_EN_In|MEM_W_EN_In → zero-extended Shift_operand_In[11:0].
  - Otherwise imm_In=1 → {24'b0, Shift_operand_In[7:0]} rotated right by 2×Shift_operand_In[11:8].
  - Otherwise Shift_operand_In[4]=0 → Val_Rm_In shifted by Shift_operand_In[11:7]. Type Shift_operand_In[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. An amount of 0 is the identity for all types.
  - Shift_operand_In[4]=1 (register shift, unsupported) → Val_Rm_In unshifted.
- ALU (a = Val_Rn_In, b = Val2):
  - MOV 0001 → b
  - MVN 1001 → ~b
  - ADD 0010 → a+b
  - ADC 0011 → a+b+C
  - SUB 0100 → a−b
  - SBC 0101 → a−b−!C, computed as a+~b+C
  - AND 0110 → a&b
  - ORR 0111 → a|b
  - EOR 1000 → a^b
  - Any other code → result 0, flags unchanged.
- Flags:
  - N = res[31]; Z = (res==0).
  - Arithmetic ops: C = 33rd sum bit, computed as a+~b+1 for SUB. V = signed overflow.
  - Logical ops and MOV/MVN keep the current C and V.
- SR: loads the new flags on the rising edge when S_In & ~freeze; otherwise holds.
- Branch_Address = PC_In + (sign-extend(Signed_imm_24_In) << 2), 32-bit, wraps modulo 2^32.
- EX/MEM register: loads all registered outputs each edge unless freeze=1, which holds them. No flush port; ID/EX flush already inserts the bubble.

## Timing
- Reset (async, RST=0): SR=SR_RESET; every registered output is 0.
- ID/EX values at edge k → ALU_Res_Out etc. valid after edge k+1. Latency 1.
- The SR update from an instruction is visible to the instruction decoded in the same cycle (ID reads SR combinationally after the edge).
- freeze=1 together with S_In=1: SR is not written. The instruction re-presents its inputs on unfreeze and updates then.
- Reset asserted mid-stall: cleared immediately, and freeze is ignored while RST=0.

## Configuration
- EXE_FORWARDING_EN defined:
  - Adds ports Sel_Src1 in 2, Sel_Src2 in 2, MEM_ALU_Res_In in 32, WB_Value_In in 32.
  - Select codes: 00 → ID value, 01 → MEM_ALU_Res_In, 10 → WB_Value_In, 11 → ID value.
  - Sel_Src1 muxes Val_Rn_In. Sel_Src2 muxes Val_Rm_In before both Val2 and Val_Rm_Out.
- Undefined: these ports are absent and operands come straight from the ID/EX inputs.

## Structure
- Package exe_pkg: EXE_CMD localparams, shift-type codes, SR bit indices (SR_N=3, SR_Z=2, SR_C=1, SR_V=0).
- Sub-module exe_alu: combinational ALU plus flag generation, taking a, b, cin and cmd and returning res and nzcv.
- Val2 generator, SR and EX/MEM register stay in exe_stage.

## Test plan
- Reset: drive RST=0 mid-run → SR=0000 and all registered outputs 0 immediately. Release, then ADD 5+7 → ALU_Res_Out=12 one cycle later.
- SUB with S=1, Rn=3, Val2=3 → ALU_Res_Out=0, SR=0110 (Z=1, C=1). ADD with S=1, 0x7FFFFFFF+1 → 0x80000000, SR=1001.
- Immediate: imm=1, Shift_operand=0x4FF → Val2 = 0xFF rotated right by 8 = 0xFF000000. MOV result 0xFF000000.
- Shift: Rm=0x80000000, ASR by 4 → 0xF8000000. ROR by 1 of 0x00000001 → 0x80000000.
- Branch: PC_In=0x100, Signed_imm_24=0xFFFFFE → Branch_Address=0xF8, Branch_Taken=1 same cycle.
- freeze held 3 cycles with S=1 → outputs and SR unchanged; updated on the first unfrozen edge. With EXE_FORWARDING_EN, Sel_Src1=01 and MEM_ALU_Res_In=10 in ADD 10+1 → 11.
